spi_ram_bridge: RTL and testbench
=================================

Name: spi_ram_bridge

Overview:
Parametrised SPI-slave-to-memory bridge: a serial frame on mosi/ss_n carries a 2-bit opcode followed by an address or data payload.
Adds configurable data/address width and depth, plus burst (auto-increment) reads and writes across a single frame.
Sits at the chip boundary as the serial-accessible register/scratch RAM; one clock domain, where SPI SCK is the system clk.

Parameters:
DATA_W, 8, memory word width and bits per data word on the wire
ADDR_W, 8, address payload width; pointer register width
DEPTH, 256, number of words; legal range 2..2**ADDR_W
AUTO_INC, 1, 1 = pointer increments after each data word (burst); 0 = pointer held

Ports:
clk  input  1  system/SPI clock; all sampling on rising edge
rst_n  input  1  asynchronous active-low reset
ss_n  input  1  slave select, active low; frame = contiguous low period
mosi  input  1  serial in, MSB first
miso  output  1  serial out, MSB first; 0 when not shifting read data
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, miso=0, busy=0, wr_ptr=0, rd_ptr=0, shift regs/bit counters 0; memory contents not cleared.
- Opcodes (op[1:0]): 00 WR_ADDR (load wr_ptr), 01 WR_DATA, 10 RD_ADDR (load rd_ptr), 11 RD_DATA.
- Edge numbering: C0 = first rising edge with ss_n sampled 0 while in IDLE.
- IDLE: at C0 capture mosi as op[1] -> CMD. CMD: at C1 capture op[0] -> ADDR, WRITE or READ per opcode.
- ADDR: ADDR_W bits sampled at C2..C2+ADDR_W-1; at last bit, load wr_ptr or rd_ptr -> DONE.
- DONE: ignore mosi until ss_n high.
- WRITE: DATA_W bits per word from C2. At each word's last bit, mem[wr_ptr] <= word. If AUTO_INC, wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1. Continue for further words while ss_n low.
- READ: at edge C2 load tx shift reg with mem[rd_ptr]; miso = word MSB after C2, next bit after each following edge.
  - Word n occupies the cycles after edges C2+n*DATA_W .. C2+n*DATA_W+DATA_W-1.
  - Next word loads at edge C2+(n+1)*DATA_W with no gap. If AUTO_INC, rd_ptr advances (same wrap) at each load, so the prefetch must be ready.
  - mosi is ignored in READ.
- ss_n sampled high in any non-IDLE state: -> IDLE at that edge; miso=0 and busy=0 from that edge. Partial words are discarded (no write, no pointer change). Completed words and pointer updates stand.
- Address >= DEPTH (only when DEPTH < 2**ADDR_W): pointer loads as given; writes to it are dropped; reads return 0; increment from an out-of-range value wraps to 0.
- AUTO_INC=0: repeated words in one frame hit the same address (last write wins; reads repeat the same word).
- Reset mid-frame: immediate abort as above; pointers return to 0.
- Write and read never occur in the same cycle (one opcode per frame), so a single-port memory suffices.
- busy = (state != IDLE), registered.

Decomposition:
- Package spi_ram_pkg: opcode localparams (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA), FSM state encoding (IDLE, CMD, ADDR, WRITE, READ, DONE).
- Sub-module spi_ram_mem: DEPTH x DATA_W single-port, synchronous write, combinational or registered read. If registered, the top issues the read one cycle before each load (at C1 and at each word's penultimate bit).
- Shift/count logic and FSM stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-WRITE frame -> miso=0, busy=0 immediately; after release, RD_ADDR 0x00 then RD_DATA returns pre-reset memory unchanged.
- Single write/read: WR_ADDR 0x10, WR_DATA 0xA5; RD_ADDR 0x10, RD_DATA -> miso shows 1010_0101 starting the cycle after C2.
- Burst wrap (DEPTH=256): WR_ADDR 0xFE, WR_DATA frame 0x11,0x22,0x33 -> mem[FE]=11, mem[FF]=22, mem[00]=33. RD_ADDR 0xFE, RD_DATA for 24 bits -> 11,22,33 with no gap bits.
- Aborted word: WR_ADDR 0x20, WR_DATA sending 5 of 8 bits then ss_n high -> mem[20] unchanged, busy low at the abort edge; next full WR_DATA 0x5A lands at 0x20.
- AUTO_INC=0: WR_DATA 0x01,0x02 at addr 0x30 -> mem[30]=02, mem[31] unchanged; 16-bit read -> 02,02.
- DEPTH=200, ADDR_W=8: WR_ADDR 0xD0, WR_DATA 0x77 -> no write. RD from 0xD0 -> miso all 0. Burst read from 0xC7 -> mem[C7] then mem[00].

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared opcodes and FSM encoding for the SPI-to-RAM bridge.
// Pure declarations: no latency, no flow control.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// DEPTH x DATA_W single-port RAM: synchronous write, combinational read.
// Out-of-range addresses drop writes and read as zero; no backpressure.
module spi_ram_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // Extra MSB keeps the compare meaningful when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign idx      = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = in_range ? mem[idx] : '0;

endmodule

// File: rtl/spi_ram_bridge.sv
// SPI-slave frame decoder driving a RAM: 2-bit opcode then address or data words, MSB first.
// Read data appears on miso the cycle after each load edge with no inter-word gap; ss_n high aborts at once.
module spi_ram_bridge
    import spi_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int AUTO_INC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic busy
);

    localparam int CNT_MAX = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0]   ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0]   DATA_LAST = CW'(DATA_W - 1);
    localparam logic [ADDR_W:0] PTR_LAST  = (ADDR_W+1)'(DEPTH - 1);

    state_t            state, state_nxt;
    logic              op_hi;
    logic [CW-1:0]     bit_cnt;
    logic [CNT_MAX-2:0] rx_sh;
    logic [CNT_MAX-1:0] rx_in;
    logic [DATA_W-1:0] tx_sh;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, mem_addr;
    logic [DATA_W-1:0] rdata;
    logic              we, abort;

    // Out-of-range pointers also wrap to 0 on increment.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return ({1'b0, p} >= PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign rx_in    = {rx_sh, mosi};
    assign abort    = ss_n && (state != IDLE);
    assign mem_addr = (state == WRITE) ? wr_ptr : rd_ptr;

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        case (state)
            IDLE:  if (!ss_n) state_nxt = CMD;
            CMD: begin
                case ({op_hi, mosi})
                    OP_WR_DATA: state_nxt = WRITE;
                    OP_RD_DATA: state_nxt = READ;
                    default:    state_nxt = ADDR;
                endcase
            end
            ADDR:  if (bit_cnt == ADDR_LAST) state_nxt = DONE;
            WRITE: we = (bit_cnt == DATA_LAST);
            READ:  state_nxt = READ;
            DONE:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            we        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_hi   <= 1'b0;
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            miso    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            miso <= 1'b0;
            if (abort) begin
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        if (!ss_n) op_hi <= mosi;
                    end
                    CMD: bit_cnt <= '0;
                    ADDR: begin
                        rx_sh   <= rx_in[CNT_MAX-2:0];
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == ADDR_LAST) begin
                            if (op_hi) rd_ptr <= rx_in[ADDR_W-1:0];
                            else       wr_ptr <= rx_in[ADDR_W-1:0];
                        end
                    end
                    WRITE: begin
                        rx_sh <= rx_in[CNT_MAX-2:0];
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (AUTO_INC != 0) wr_ptr <= ptr_inc(wr_ptr);
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    READ: begin
                        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + CW'(1);
                        // Word boundary: fetch and present the MSB in the same edge.
                        if (bit_cnt == '0) begin
                            miso  <= rdata[DATA_W-1];
                            tx_sh <= {rdata[DATA_W-2:0], 1'b0};
                            if (AUTO_INC != 0) rd_ptr <= ptr_inc(rd_ptr);
                        end else begin
                            miso  <= tx_sh[DATA_W-1];
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: bit_cnt <= '0;
                endcase
            end
        end
    end

    spi_ram_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (mem_addr),
        .wdata (rx_in[DATA_W-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Bench: three bridge instances (burst, no-increment, DEPTH=200) against a frame-level memory model.
module tb_spi_ram_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mosi;
    logic [2:0] ss_n;
    logic [2:0] miso;
    logic [2:0] busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [3][256];
    int         wp [3];
    int         rp [3];
    int         depth [3] = '{256, 256, 200};
    int         ainc  [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(1)) u0 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n[0]), .mosi(mosi), .miso(miso[0]), .busy(busy[0]));
    spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(0)) u1 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n[1]), .mosi(mosi), .miso(miso[1]), .busy(busy[1]));
    spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .AUTO_INC(1)) u2 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n[2]), .mosi(mosi), .miso(miso[2]), .busy(busy[2]));

    function automatic int next_ptr(input int k, input int p);
        return (p >= depth[k] - 1) ? 0 : p + 1;
    endfunction

    // One frame: opcode, payload bits, then ss_n high. rx[j] is miso after the edge sampling payload bit j.
    task automatic frame(input int k, input logic [1:0] op, input bit pl[$],
                         output logic rx[$], output logic busy_end, output logic miso_end);
        rx = {};
        @(negedge clk); ss_n[k] = 1'b0; mosi = op[1];
        @(negedge clk); mosi = op[0];
        for (int j = 0; j < pl.size(); j++) begin
            @(negedge clk);
            if (j > 0) rx.push_back(miso[k]);
            mosi = pl[j];
        end
        @(negedge clk);
        if (pl.size() > 0) rx.push_back(miso[k]);
        ss_n[k] = 1'b1;
        mosi = 1'($urandom);
        @(negedge clk);
        busy_end = busy[k];
        miso_end = miso[k];
    endtask

    task automatic set_ptr(input int k, input bit is_rd, input int a);
        bit pl[$];
        logic rx[$];
        logic be, me;
        for (int b = 7; b >= 0; b--) pl.push_back(1'((a >> b) & 1));
        frame(k, {is_rd, 1'b0}, pl, rx, be, me);
        if (is_rd) rp[k] = a; else wp[k] = a;
    endtask

    task automatic wr_data(input int k, input logic [7:0] w[$], input int extra, output logic busy_end);
        bit pl[$];
        logic rx[$];
        logic me;
        for (int i = 0; i < w.size(); i++)
            for (int b = 7; b >= 0; b--) pl.push_back(w[i][b]);
        for (int i = 0; i < extra; i++) pl.push_back(1'($urandom));
        frame(k, 2'b01, pl, rx, busy_end, me);
        for (int i = 0; i < w.size(); i++) begin
            if (wp[k] < depth[k]) mdl[k][wp[k]] = w[i];
            if (ainc[k] != 0) wp[k] = next_ptr(k, wp[k]);
        end
    endtask

    task automatic rd_data(input int k, input int n, output logic [7:0] got[$],
                           output logic [7:0] exp[$], output logic miso_end);
        bit pl[$];
        logic rx[$];
        logic be;
        logic [7:0] word;
        int p;
        got = {};
        exp = {};
        for (int i = 0; i < n * 8; i++) pl.push_back(1'($urandom));
        frame(k, 2'b11, pl, rx, be, miso_end);
        for (int i = 0; i < n; i++) begin
            word = 8'h00;
            for (int b = 0; b < 8; b++) word = {word[6:0], rx[i*8 + b]};
            got.push_back(word);
        end
        p = rp[k];
        for (int i = 0; i < n; i++) begin
            exp.push_back((p < depth[k]) ? mdl[k][p] : 8'h00);
            if (ainc[k] != 0) p = next_ptr(k, p);
        end
        rp[k] = p;
    endtask

    task automatic test_reset_state;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy[k] !== 1'b0) begin
                errors++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]);
            end
            checks++;
            if (miso[k] !== 1'b0) begin
                errors++; $display("FAIL reset_miso[%0d]: got %b want 0", k, miso[k]);
            end
        end
    endtask

    task automatic init_memory;
        logic [7:0] q[$];
        logic be;
        for (int k = 0; k < 3; k += 2) begin
            q = {};
            for (int i = 0; i < depth[k]; i++) q.push_back(8'($urandom));
            set_ptr(k, 1'b0, 0);
            wr_data(k, q, 0, be);
        end
        for (int a = 0; a < 256; a++) begin
            q = {};
            q.push_back(8'($urandom));
            set_ptr(1, 1'b0, a);
            wr_data(1, q, 0, be);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] got[$], exp[$];
        logic me;
        @(negedge clk); ss_n[0] = 1'b0; mosi = 1'b0;
        @(negedge clk); mosi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mosi = 1'($urandom);
        end
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++; $display("FAIL rst_busy_before: got %b want 1", busy[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++; $display("FAIL rst_busy_async: got %b want 0", busy[0]);
        end
        checks++;
        if (miso[0] !== 1'b0) begin
            errors++; $display("FAIL rst_miso_async: got %b want 0", miso[0]);
        end
        ss_n[0] = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin wp[k] = 0; rp[k] = 0; end
        rd_data(0, 2, got, exp, me);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++; $display("FAIL rst_mem_keep[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_single;
        logic [7:0] w[$], got[$], exp[$];
        logic be, me;
        w = {8'hA5};
        set_ptr(0, 1'b0, 8'h10);
        wr_data(0, w, 0, be);
        set_ptr(0, 1'b1, 8'h10);
        rd_data(0, 1, got, exp, me);
        checks++;
        if (got[0] !== 8'hA5) begin
            errors++; $display("FAIL single_rd: got %h want a5", got[0]);
        end
        checks++;
        if (me !== 1'b0) begin
            errors++; $display("FAIL single_miso_idle: got %b want 0", me);
        end
    endtask

    task automatic test_burst_wrap;
        logic [7:0] w[$], got[$], exp[$];
        logic be, me;
        w = {8'h11, 8'h22, 8'h33};
        set_ptr(0, 1'b0, 8'hFE);
        wr_data(0, w, 0, be);
        set_ptr(0, 1'b1, 8'hFE);
        rd_data(0, 3, got, exp, me);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== w[i]) begin
                errors++; $display("FAIL burst_wrap[%0d]: got %h want %h", i, got[i], w[i]);
            end
        end
    endtask

    task automatic test_aborted_word;
        logic [7:0] w[$], got[$], exp[$];
        logic be, me;
        w = {};
        set_ptr(0, 1'b0, 8'h20);
        wr_data(0, w, 5, be);
        checks++;
        if (be !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got %b want 0", be);
        end
        set_ptr(0, 1'b1, 8'h20);
        rd_data(0, 1, got, exp, me);
        checks++;
        if (got[0] !== exp[0]) begin
            errors++; $display("FAIL abort_nowrite: got %h want %h", got[0], exp[0]);
        end
        w = {8'h5A};
        wr_data(0, w, 0, be);
        set_ptr(0, 1'b1, 8'h20);
        rd_data(0, 1, got, exp, me);
        checks++;
        if (got[0] !== 8'h5A) begin
            errors++; $display("FAIL abort_then_write: got %h want 5a", got[0]);
        end
    endtask

    task automatic test_no_inc;
        logic [7:0] w[$], got[$], exp[$];
        logic be, me;
        w = {8'h01, 8'h02};
        set_ptr(1, 1'b0, 8'h30);
        wr_data(1, w, 0, be);
        set_ptr(1, 1'b1, 8'h30);
        rd_data(1, 2, got, exp, me);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] !== 8'h02) begin
                errors++; $display("FAIL noinc_repeat[%0d]: got %h want 02", i, got[i]);
            end
        end
        set_ptr(1, 1'b1, 8'h31);
        rd_data(1, 1, got, exp, me);
        checks++;
        if (got[0] !== exp[0]) begin
            errors++; $display("FAIL noinc_neighbour: got %h want %h", got[0], exp[0]);
        end
    endtask

    task automatic test_depth_limit;
        logic [7:0] w[$], got[$], exp[$];
        logic be, me;
        w = {8'h77};
        set_ptr(2, 1'b0, 8'hD0);
        wr_data(2, w, 0, be);
        set_ptr(2, 1'b1, 8'hD0);
        rd_data(2, 1, got, exp, me);
        checks++;
        if (got[0] !== 8'h00) begin
            errors++; $display("FAIL oor_read: got %h want 00", got[0]);
        end
        set_ptr(2, 1'b1, 8'hC7);
        rd_data(2, 2, got, exp, me);
        checks++;
        if (got[0] !== mdl[2][199]) begin
            errors++; $display("FAIL depth_last: got %h want %h", got[0], mdl[2][199]);
        end
        checks++;
        if (got[1] !== mdl[2][0]) begin
            errors++; $display("FAIL depth_wrap: got %h want %h", got[1], mdl[2][0]);
        end
    endtask

    task automatic test_random;
        logic [7:0] w[$], got[$], exp[$];
        logic be, me;
        int k, n;
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 2);
            n = $urandom_range(1, 3);
            case ($urandom_range(0, 3))
                0: set_ptr(k, 1'b0, $urandom_range(0, 255));
                1: begin
                    w = {};
                    for (int i = 0; i < n; i++) w.push_back(8'($urandom));
                    wr_data(k, w, $urandom_range(0, 7), be);
                    checks++;
                    if (be !== 1'b0) begin
                        errors++; $display("FAIL rand_wr_busy it%0d: got %b want 0", it, be);
                    end
                end
                2: set_ptr(k, 1'b1, $urandom_range(0, 255));
                default: begin
                    rd_data(k, n, got, exp, me);
                    for (int i = 0; i < n; i++) begin
                        checks++;
                        if (got[i] !== exp[i]) begin
                            errors++;
                            $display("FAIL rand_rd it%0d inst%0d word%0d: got %h want %h", it, k, i, got[i], exp[i]);
                        end
                    end
                    checks++;
                    if (me !== 1'b0) begin
                        errors++; $display("FAIL rand_miso_idle it%0d: got %b want 0", it, me);
                    end
                end
            endcase
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ss_n  = 3'b111;
        mosi  = 1'b0;
        for (int k = 0; k < 3; k++) begin wp[k] = 0; rp[k] = 0; end
        @(negedge clk);
        @(negedge clk);
        test_reset_state();
        rst_n = 1'b1;
        init_memory();
        test_reset_mid_frame();
        test_single();
        test_burst_wrap();
        test_aborted_word();
        test_no_inc();
        test_depth_limit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
